// File: rtl/timer_irq.sv
// Memory-mapped programmable down-counter that raises the interrupt request for one HWInt bit.
// Expiry holds irq in one-shot mode, or gives one-cycle repeating pulses in auto-reload mode.
module timer_irq #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_e;

  state_e      state_q;
  logic [3:0]  ctrl_q;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic        irq_flag_q;

  logic        hit_s;
  logic        wr_ctrl_s;
  logic        wr_preset_s;
  logic        auto_reload_s;
  logic        unused_s;

  assign hit_s         = (addr[31:4] == BASE_ADDR[31:4]);
  assign wr_ctrl_s     = we & hit_s & (addr[3:2] == 2'd0);
  assign wr_preset_s   = we & hit_s & (addr[3:2] == 2'd1);
  assign auto_reload_s = (ctrl_q[2:1] == 2'b01);
  assign unused_s      = ^addr[1:0];

  // Counter FSM and register file; bus writes are applied last so they override FSM updates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ctrl_q[0]) begin
            state_q <= LOAD;
          end else begin
            state_q <= IDLE;
          end
        end
        LOAD: begin
          count_q <= preset_q;
          state_q <= CNT;
        end
        CNT: begin
          if (!ctrl_q[0]) begin
            state_q <= IDLE;
          end else if (count_q <= 32'd1) begin
            count_q    <= 32'd0;
            irq_flag_q <= 1'b1;
            state_q    <= INT;
          end else begin
            count_q <= count_q - 32'd1;
          end
        end
        INT: begin
          // Auto-reload keeps EN so the IDLE->LOAD path restarts the count.
          if (auto_reload_s) begin
            irq_flag_q <= 1'b0;
          end else begin
            ctrl_q[0] <= 1'b0;
          end
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      if (wr_preset_s) begin
        preset_q <= din;
      end
      if (wr_ctrl_s) begin
        ctrl_q     <= din[3:0];
        irq_flag_q <= 1'b0;
      end
    end
  end

  // Read mux, decoded from addr[3:2] regardless of window hit.
  always_comb begin
    dout = 32'd0;
    case (addr[3:2])
      2'd0:    dout = {28'd0, ctrl_q};
      2'd1:    dout = preset_q;
      2'd2:    dout = count_q;
      default: dout = 32'd0;
    endcase
  end

  assign irq = irq_flag_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_irq.sv
// Directed self-checking bench for timer_irq.
module tb_timer_irq;

  localparam logic [31:0] BASE    = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL  = BASE + 32'h0;
  localparam logic [31:0] A_PRE   = BASE + 32'h4;
  localparam logic [31:0] A_CNT   = BASE + 32'h8;
  localparam logic [31:0] A_RSV   = BASE + 32'hC;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int errors = 0;
  int checks = 0;

  timer_irq #(.BASE_ADDR(BASE)) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    tick();
    we   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = dout;
  endtask

  logic [31:0] rd;

  initial begin
    reset = 1'b0;
    addr  = 32'd0;
    we    = 1'b0;
    din   = 32'd0;
    #2;
    chk("rst_irq", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    bus_read(A_CTRL, rd); chk("rst_ctrl", rd, 32'd0);
    bus_read(A_PRE, rd);  chk("rst_preset", rd, 32'd0);
    bus_read(A_CNT, rd);  chk("rst_count", rd, 32'd0);
    bus_read(A_RSV, rd);  chk("rst_rsv", rd, 32'd0);

    // One-shot: PRESET=5, enable at edge 0, irq after edge 7 and held.
    bus_write(A_PRE, 32'd5);
    bus_write(A_CTRL, 32'h9);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 2) begin
        bus_read(A_CNT, rd); chk("os_count_loaded", rd, 32'd5);
      end
      chk($sformatf("os_irq_e%0d", k), {31'd0, irq}, (k >= 7) ? 32'd1 : 32'd0);
    end
    bus_read(A_CTRL, rd); chk("os_ctrl_after", rd, 32'h8);
    bus_read(A_CNT, rd);  chk("os_count_after", rd, 32'd0);
    bus_write(A_CTRL, 32'h0);
    chk("os_irq_cleared", {31'd0, irq}, 32'd0);
    tick();

    // Auto-reload: PRESET=5, pulses rising after edges 7,15,23,31,39.
    bus_write(A_CTRL, 32'hB);
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk($sformatf("ar_irq_e%0d", k), {31'd0, irq},
          (k == 7 || k == 15 || k == 23 || k == 31 || k == 39) ? 32'd1 : 32'd0);
    end
    bus_read(A_CTRL, rd); chk("ar_ctrl_kept", rd, 32'hB);
    bus_write(A_CTRL, 32'h0);
    tick(); tick(); tick();

    // PRESET=0 masked: irq stays low, but expiry still clears EN.
    bus_write(A_PRE, 32'd0);
    bus_write(A_CTRL, 32'h1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("mask_irq_e%0d", k), {31'd0, irq}, 32'd0);
    end
    bus_read(A_CTRL, rd); chk("mask_ctrl_cleared", rd, 32'h0);

    // PRESET=0 unmasked: irq after edge 3.
    bus_write(A_CTRL, 32'h9);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("p0_irq_e%0d", k), {31'd0, irq}, (k >= 3) ? 32'd1 : 32'd0);
    end
    bus_write(A_CTRL, 32'h0);
    chk("p0_irq_cleared", {31'd0, irq}, 32'd0);
    tick();

    // Disable mid-count: PRESET=100, CTRL=0 written at edge 10.
    bus_write(A_PRE, 32'd100);
    bus_write(A_CTRL, 32'h9);
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("dis_irq_e%0d", k), {31'd0, irq}, 32'd0);
    end
    bus_write(A_CTRL, 32'h0);
    tick(); tick();
    bus_read(A_CNT, rd);
    chk("dis_count_range", {31'd0, (rd >= 32'd91 && rd <= 32'd93)}, 32'd1);
    for (int k = 1; k <= 10; k++) begin
      tick();
    end
    chk("dis_irq_low", {31'd0, irq}, 32'd0);
    bus_read(A_CNT, rd);
    chk("dis_count_frozen", {31'd0, (rd >= 32'd91 && rd <= 32'd93)}, 32'd1);

    // Decode: writes outside the window or to read-only registers change nothing.
    bus_write(BASE + 32'h14, 32'h0000_FFFF);
    bus_write(BASE + 32'h10, 32'h0000_000F);
    bus_write(A_CNT, 32'h0000_0055);
    bus_write(A_RSV, 32'h1234_5678);
    bus_read(A_PRE, rd);  chk("dec_preset", rd, 32'd100);
    bus_read(A_CTRL, rd); chk("dec_ctrl", rd, 32'd0);
    bus_read(A_RSV, rd);  chk("dec_rsv", rd, 32'd0);
    bus_read(A_CNT, rd);
    chk("dec_count", {31'd0, (rd >= 32'd91 && rd <= 32'd93)}, 32'd1);
    tick();

    // Async reset mid-count, then with irq held high.
    bus_write(A_PRE, 32'd5);
    bus_write(A_CTRL, 32'h9);
    tick(); tick(); tick(); tick();
    bus_read(A_CNT, rd); chk("mid_count", rd, 32'd3);
    #2;
    reset = 1'b0;
    #1;
    bus_read(A_CNT, rd); chk("mid_rst_count", rd, 32'd0);
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    tick();
    reset = 1'b1;
    bus_write(A_PRE, 32'd5);
    bus_write(A_CTRL, 32'h9);
    for (int k = 1; k <= 7; k++) begin
      tick();
    end
    chk("pre_rst_irq_high", {31'd0, irq}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_irq_drop", {31'd0, irq}, 32'd0);
    bus_read(A_CTRL, rd); chk("rst2_ctrl", rd, 32'd0);
    bus_read(A_PRE, rd);  chk("rst2_preset", rd, 32'd0);
    tick();
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_irq.md
# timer_irq

Memory-mapped programmable down-counter that generates the hardware interrupt line consumed by the coprocessor's `HWInt` input, so it sits on the interrupt-producer side of the CP0 interface. The CPU programs and reads it through the system bridge with word loads and stores. On expiry it raises `irq` either as a held level (one-shot mode) or as a single-cycle pulse that repeats (auto-reload mode).

## Interface
- `BASE_ADDR`, default `32'h0000_7F00`: base of the 16-byte register window; only bits [31:4] are compared.
- `clk` input, 1 bit: system clock. All state changes on the rising edge.
- `reset` input, 1 bit: reset, asynchronous and active-low. While 0, all state is cleared immediately.
- `addr` input, 32 bits: byte address from the bridge. `addr[3:2]` selects the register.
- `we` input, 1 bit: write strobe, sampled at `clk` rise.
- `din` input, 32 bits: write data.
- `dout` output, 32 bits: read data, combinational from `addr[3:2]`.
- `irq` output, 1 bit: interrupt request, drives one `HWInt` bit.

## Operation
- A hit is `addr[31:4] == BASE_ADDR[31:4]`. A write happens only when `we` is 1 and the access is a hit.
- Registers, selected by `addr[3:2]`:
  - 0 = CTRL. Only bits [3:0] are stored: [0] EN (enable), [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM (interrupt mask).
  - 1 = PRESET, 32 bits, read/write.
  - 2 = COUNT, 32 bits, read-only; writes to it are ignored.
  - 3 = reserved; reads return 0 and writes are ignored.
- `dout` returns the register selected by `addr[3:2]` regardless of hit. CTRL is zero-extended to 32 bits.
- Any CTRL write clears the internal `irq_flag`.
- `irq = irq_flag & CTRL.IM`. This is purely combinational, with no extra register stage.
- FSM states are IDLE, LOAD, CNT and INT:
  - IDLE: if EN is 1, go to LOAD. Otherwise stay; COUNT holds its value.
  - LOAD: `COUNT <= PRESET`, then go to CNT.
  - CNT:
    - If EN is 0, go to IDLE and COUNT freezes.
    - Else if COUNT ≤ 1: `COUNT <= 0`, `irq_flag <= 1`, go to INT.
    - Else `COUNT <= COUNT - 1`.
  - INT:
    - MODE 00: clear EN and go to IDLE. `irq_flag` stays 1 until a CTRL write clears it.
    - MODE 01: `irq_flag <= 0` and go to IDLE. EN stays 1, so counting restarts.
- Simultaneous events:
  - A bus write to CTRL in the same cycle that INT clears EN: the bus write wins for all CTRL bits, and `irq_flag` is cleared.
  - A PRESET write during CNT does not affect COUNT until the next LOAD.
  - A PRESET write in the same cycle as LOAD: LOAD uses the old PRESET value (register read before the edge).
- PRESET of 0 or 1 both expire after exactly one CNT cycle. COUNT never underflows or wraps.

## Timing
- Reset values: CTRL = 0, PRESET = 0, COUNT = 0, `irq_flag` = 0, state = IDLE. As a result `irq` = 0 and `dout` = 0 for addr[3:2] ∈ {0,1,2,3}.
- Latency for PRESET = N ≥ 1, with a CTRL write setting EN at edge E:
  - LOAD is entered at E+1.
  - COUNT = N after E+2.
  - `irq_flag` = 1 after edge E+N+2.
- Auto-reload:
  - `irq` is high for exactly 1 cycle.
  - Successive rising edges of `irq` are N+3 cycles apart.
- Disabling through CTRL mid-count:
  - The FSM returns to IDLE within 1 edge.
  - COUNT keeps its last decremented value.
- Re-enabling always reloads PRESET. The counter never resumes from a frozen COUNT.
- Reset asserted mid-operation: state and all registers clear asynchronously, and `irq` drops in the same cycle without waiting for `clk`.
- `dout` is valid in the same cycle as `addr` and reflects register values after the last edge.

## Test plan
- Reset: drive `reset`=0 mid-count. Required: `irq`=0 and COUNT=0 immediately, with no `clk` edge. After release, reading CTRL, PRESET and COUNT returns 0.
- One-shot:
  - Setup: PRESET=5, CTRL=`32'h9` (EN=1, MODE=00, IM=1) written at edge 0.
  - Required: `irq` rises after edge 7 and stays high; CTRL reads `32'h8` and COUNT reads 0.
  - A CTRL write of 0 drops `irq` after that edge.
- Auto-reload:
  - Setup: PRESET=5, CTRL=`32'hB` (EN=1, MODE=01, IM=1).
  - Required: 1-cycle `irq` pulses with rising edges 8 cycles apart, for at least 3 periods.
- Mask and boundary:
  - PRESET=0 with CTRL=`32'h1` (IM=0): `irq` stays 0, but the FSM still reaches INT and CTRL becomes 0.
  - Repeat with IM=1: `irq` rises after edge 3 relative to the enable write.
- Disable and address decode:
  - PRESET=100; enable, then write CTRL=0 after 10 cycles. Required: COUNT freezes at a value in 91..93 and `irq` never rises.
  - A write with `addr` = BASE+`32'h10` changes no register.
  - A write to COUNT is ignored.
